// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and fetch constants.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP,
        S_FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [63:0] PC_INC = 64'd4;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect and stale-response dropping.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap into FAULT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_F,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [63:0] PC_F,
    output logic [31:0] Instr_F,
    output logic        valid_F,
    output logic        misalign_F
);

    fetch_state_t state, state_nxt;
    logic [63:0]  pc;
    logic [63:0]  redir_tgt;
    logic         redir_bad;
    logic         stale;
    logic         waiting;
    logic         accepting;
    logic         owed_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_tgt = redirect_pc;
    assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
    assign redir_tgt = redirect_pc & ~64'd3;
    assign redir_bad = 1'b0;
`endif

    // A response is still owed by memory after this edge unless it arrives now.
    assign waiting   = (state == S_WAIT) || (state == S_DROP) || ((state == S_FAULT) && stale);
    assign accepting = (state == S_REQ) && imem_req_ready;
    assign owed_next = (waiting && !imem_rsp_valid) || accepting;

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;

    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        if (redirect_valid) begin
            if (redir_bad)      state_nxt = S_FAULT;
            else if (owed_next) state_nxt = S_DROP;
            else                state_nxt = S_REQ;
        end else begin
            case (state)
                S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
                S_WAIT:  if (imem_rsp_valid) state_nxt = S_HOLD;
                S_HOLD:  if (en_F)           state_nxt = S_REQ;
                S_DROP:  if (imem_rsp_valid) state_nxt = S_REQ;
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= owed_next ? S_DROP : S_REQ;
            stale <= 1'b0;
        end else begin
            state <= state_nxt;
            stale <= (state_nxt == S_FAULT) && owed_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            PC_F    <= '0;
            Instr_F <= NOP;
            valid_F <= 1'b0;
        end else if (redirect_valid) begin
            pc      <= redir_tgt;
            Instr_F <= NOP;
            valid_F <= 1'b0;
        end else if ((state == S_WAIT) && imem_rsp_valid) begin
            PC_F    <= pc;
            Instr_F <= imem_rsp_data;
            valid_F <= 1'b1;
        end else if ((state == S_HOLD) && en_F) begin
            pc      <= pc + PC_INC;
            Instr_F <= NOP;
            valid_F <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)                 misalign_F <= 1'b0;
        else if (redirect_valid) misalign_F <= redir_bad;
    end
`else
    assign misalign_F = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model feeds the DUT,
// expected fetches are queued by the stimulus and popped when valid_F rises.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_F;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [63:0] PC_F;
    logic [31:0] Instr_F;
    logic        valid_F;
    logic        misalign_F;

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_F           (en_F),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PC_F           (PC_F),
        .Instr_F        (Instr_F),
        .valid_F        (valid_F),
        .misalign_F     (misalign_F)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [63:0] addr; int cnt; } pend_t;

    exp_t  sb[$];
    pend_t pend[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    int    acc_cyc = 0;
    int    lat    = 1;
    bit    chk_lat = 1'b0;
    bit    rose;
    logic  prev_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a == 64'h0) ? 32'h0010_0093 : (a[31:0] ^ 32'hC0DE_0003);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic [63:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    // One clock: sample pre-edge, advance, run memory model and scoreboard monitor.
    task automatic tick();
        bit          acc;
        logic [63:0] acc_addr;
        pend_t       p;
        exp_t        e;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (acc) acc_cyc = cyc;
        @(posedge clk);
        cyc++;
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (acc) begin
            p.addr = acc_addr;
            p.cnt  = lat;
            pend.push_back(p);
            check("one_outstanding", 64'(pend.size()), 64'd1);
        end
        if (pend.size() > 0) begin
            pend[0].cnt--;
            if (pend[0].cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
        end
        rose = valid_F && !prev_valid;
        if (rose) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("PC_F", PC_F, e.pc);
                check("Instr_F", 64'(Instr_F), 64'(e.instr));
                if (chk_lat) check("latency", 64'(cyc - acc_cyc), 64'd2);
            end
        end
        prev_valid = valid_F;
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = rose;
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic consume();
        en_F = 1'b1;
        tick();
        en_F = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; en_F = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        tick();
        tick();
        check("rst_valid_F", 64'(valid_F), 64'd0);
        check("rst_PC_F", PC_F, 64'h0);
        check("rst_Instr_F", 64'(Instr_F), 64'(NOP));
        check("rst_misalign_F", 64'(misalign_F), 64'd0);
        rst = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("first_req_valid", 64'(imem_req_valid), 64'd1);
        check("first_req_addr", imem_req_addr, 64'h0);

        // Basic fetch, two-cycle latency, then consume
        chk_lat = 1'b1;
        push_exp(64'h0);
        wait_valid("fetch0");
        chk_lat = 1'b0;
        push_exp(64'h4);
        consume();
        check("after_consume_req", 64'(imem_req_valid), 64'd1);
        check("after_consume_addr", imem_req_addr, 64'h4);
        check("after_consume_nop", 64'(Instr_F), 64'(NOP));
        wait_valid("fetch4");

        // Stall in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_PC_F", PC_F, 64'h4);
            check("hold_Instr_F", 64'(Instr_F), 64'(mem_word(64'h4)));
            check("hold_no_req", 64'(imem_req_valid), 64'd0);
        end
        push_exp(64'h8);
        consume();
        check("hold_next_addr", imem_req_addr, 64'h8);
        wait_valid("fetch8");

        // Redirect during WAIT, stale response three cycles after accept
        lat = 3;
        consume();
        tick();
        redirect(64'h100);
        push_exp(64'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (imem_req_valid) found = 1'b1;
            else begin
                check("drop_valid_F", 64'(valid_F), 64'd0);
                tick();
            end
        end
        check("drop_req_seen", 64'(found), 64'd1);
        check("drop_req_addr", imem_req_addr, 64'h100);
        wait_valid("fetch100");
        lat = 1;

        // Redirect in the same cycle as the response
        consume();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = imem_rsp_valid;
        end
        check("same_rsp_seen", 64'(found), 64'd1);
        push_exp(64'h180);
        redirect(64'h180);
        check("same_req_valid", 64'(imem_req_valid), 64'd1);
        check("same_req_addr", imem_req_addr, 64'h180);
        check("same_valid_F", 64'(valid_F), 64'd0);
        wait_valid("fetch180");

        // Misaligned redirect
        redirect(64'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag_set", 64'(misalign_F), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fault_no_req", 64'(imem_req_valid), 64'd0);
            check("fault_valid_F", 64'(valid_F), 64'd0);
        end
        push_exp(64'h200);
        redirect(64'h200);
        check("mis_flag_clear", 64'(misalign_F), 64'd0);
        check("mis_req_addr", imem_req_addr, 64'h200);
`else
        push_exp(64'h100);
        check("mis_flag_tied", 64'(misalign_F), 64'd0);
        check("mis_req_addr", imem_req_addr, 64'h100);
`endif
        wait_valid("fetch_mis");

        // PC wrap at the top of the address space
        push_exp(64'hFFFF_FFFF_FFFF_FFFC);
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid("fetch_top");
        push_exp(64'h0);
        consume();
        check("wrap_req_addr", imem_req_addr, 64'h0);
        wait_valid("fetch_wrap");

        // Reset with a request outstanding; the post-reset response must be dropped
        lat = 2;
        consume();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_out_no_req", 64'(imem_req_valid), 64'd0);
        check("rst_out_valid_F", 64'(valid_F), 64'd0);
        check("rst_out_rsp_now", 64'(imem_rsp_valid), 64'd1);
        push_exp(64'h0);
        tick();
        check("rst_out_req", 64'(imem_req_valid), 64'd1);
        check("rst_out_addr", imem_req_addr, 64'h0);
        lat = 1;
        wait_valid("fetch_rst");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
